// File: rtl/da_fir.sv
// Distributed-arithmetic FIR MAC: eight loadable coefficient ROMs, bit-serial shift-accumulate.
// Latency: result and done one edge after the last slice is captured (16 edges after the first).
// Backpressure: CLOAD stalls slice capture; start=0 aborts the word in flight.
module da_fir #(
    parameter int ROM_DW = 20,
    parameter int ROM_AW = 8,
    parameter int NSLICE = 16,
    parameter int ACC_W  = 38
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [ROM_AW-1:0]        A0,
    input  logic [ROM_AW-1:0]        A1,
    input  logic [ROM_AW-1:0]        A2,
    input  logic [ROM_AW-1:0]        A3,
    input  logic [ROM_AW-1:0]        A4,
    input  logic [ROM_AW-1:0]        A5,
    input  logic [ROM_AW-1:0]        A6,
    input  logic [ROM_AW-1:0]        A7,
    input  logic [ROM_DW-1:0]        CIN,
    input  logic [ROM_AW+2:0]        CADDR,
    input  logic                     CLOAD,
    input  logic                     valid_in,
    input  logic                     start,
    output logic signed [ACC_W-1:0]  ACC,
    output logic                     done
);

    localparam int PW = ROM_DW + 3;
    localparam int CW = $clog2(NSLICE);

    logic [ROM_DW-1:0] rom [8][1 << ROM_AW];
    logic [ROM_AW-1:0] addr [8];

    logic signed [PW-1:0]    slice_sum;
    logic [ROM_DW-1:0]       word;
    logic                    run;
    logic [CW-1:0]           cnt;
    logic signed [PW-1:0]    p;
    logic                    p_vld;
    logic                    p_first;
    logic                    p_last;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] acc_nxt;

    assign addr[0] = A0;
    assign addr[1] = A1;
    assign addr[2] = A2;
    assign addr[3] = A3;
    assign addr[4] = A4;
    assign addr[5] = A5;
    assign addr[6] = A6;
    assign addr[7] = A7;

    assign run = start & ~CLOAD;

    // ROM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (CLOAD && valid_in)
            rom[CADDR[ROM_AW+2:ROM_AW]][CADDR[ROM_AW-1:0]] <= CIN;
    end

    always_comb begin
        slice_sum = '0;
        word      = '0;
        for (int k = 0; k < 8; k++) begin
            word      = rom[k][addr[k]];
            slice_sum = slice_sum + {{3{word[ROM_DW-1]}}, word};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            p       <= '0;
            p_vld   <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_vld <= run;
            if (run) begin
                p       <= slice_sum;
                p_first <= (cnt == '0);
                p_last  <= (cnt == CW'(NSLICE - 1));
                cnt     <= cnt + 1'b1;
            end else if (!start) begin
                cnt <= '0;
            end
        end
    end

    // The MSB slice carries negative weight, so the word starts from -P.
    assign p_ext   = {{(ACC_W-PW){p[PW-1]}}, p};
    assign acc_nxt = p_first ? -p_ext : (acc <<< 1) + p_ext;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc  <= '0;
            ACC  <= '0;
            done <= 1'b0;
        end else begin
            done <= p_vld && p_last;
            if (p_vld)
                acc <= acc_nxt;
            if (p_vld && p_last)
                ACC <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_da_fir.sv
// Self-checking bench for da_fir: directed plan cases plus a randomized op stream against an arithmetic model.
module tb_da_fir;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [7:0][7:0]   a_bus = '0;
    logic [19:0]       cin = '0;
    logic [10:0]       caddr = '0;
    logic              cload = 1'b0;
    logic              valid_in = 1'b0;
    logic              start = 1'b0;
    logic signed [37:0] acc_out;
    logic              done;

    da_fir dut (
        .clk(clk), .resetn(resetn),
        .A0(a_bus[0]), .A1(a_bus[1]), .A2(a_bus[2]), .A3(a_bus[3]),
        .A4(a_bus[4]), .A5(a_bus[5]), .A6(a_bus[6]), .A7(a_bus[7]),
        .CIN(cin), .CADDR(caddr), .CLOAD(cload), .valid_in(valid_in),
        .start(start), .ACC(acc_out), .done(done)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_CAP, OP_LOAD, OP_IDLE, OP_RST} kind_t;
    typedef struct {
        kind_t           kind;
        logic [7:0][7:0] a;
        logic [10:0]     caddr;
        logic [19:0]     cin;
        bit              vld;
        bit              st;
    } op_t;

    op_t     ops[$];
    int      rom_m[8][256];
    longint  pw[$];
    bit      due = 0;
    longint  due_val = 0;
    longint  exp_acc = 0;
    int      cyc = 0;
    int      done_cyc[$];
    longint  done_val[$];
    int      n_chk = 0;
    int      n_fail = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void add_op(input kind_t k, input logic [7:0][7:0] a,
                                   input logic [10:0] ca, input logic [19:0] ci,
                                   input bit vld, input bit st);
        op_t o;
        o.kind = k; o.a = a; o.caddr = ca; o.cin = ci; o.vld = vld; o.st = st;
        ops.push_back(o);
    endfunction

    function automatic logic [7:0][7:0] fill(input logic [7:0] v);
        logic [7:0][7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v;
        return r;
    endfunction

    function automatic void add_word(input logic [7:0][7:0] msb, input logic [7:0][7:0] rest);
        add_op(OP_CAP, msb, '0, '0, 0, 1);
        for (int s = 1; s < 16; s++) add_op(OP_CAP, rest, '0, '0, 0, 1);
    endfunction

    // Exact DA result from the sixteen per-slice lookup sums.
    function automatic longint word_value();
        longint v = -pw[0] * 32768;
        for (int b = 1; b < 16; b++) v += pw[b] * (longint'(1) << (15 - b));
        return v;
    endfunction

    task automatic run_ops();
        op_t    o;
        bit     ed;
        longint psum;
        int     w;
        while (ops.size() > 0) begin
            o = ops.pop_front();
            resetn   = (o.kind != OP_RST);
            cload    = (o.kind == OP_LOAD);
            start    = (o.kind == OP_CAP) ? 1'b1 : (o.kind == OP_IDLE) ? 1'b0 : o.st;
            valid_in = (o.kind == OP_LOAD) ? o.vld : 1'($urandom);
            caddr    = (o.kind == OP_LOAD) ? o.caddr : 11'($urandom);
            cin      = (o.kind == OP_LOAD) ? o.cin : 20'($urandom);
            a_bus    = (o.kind == OP_CAP) ? o.a : {$urandom, $urandom};
            @(posedge clk);
            #1;
            cyc++;
            ed = due;
            if (due) exp_acc = due_val;
            due = 0;
            case (o.kind)
                OP_CAP: begin
                    psum = 0;
                    for (int k = 0; k < 8; k++) psum += rom_m[k][o.a[k]];
                    pw.push_back(psum);
                    if (pw.size() == 16) begin
                        due = 1;
                        due_val = word_value();
                        pw.delete();
                    end
                end
                OP_LOAD: begin
                    if (o.vld) begin
                        w = int'(o.cin);
                        if (o.cin[19]) w -= (1 << 20);
                        rom_m[o.caddr[10:8]][o.caddr[7:0]] = w;
                    end
                    if (!o.st) pw.delete();
                end
                OP_IDLE: pw.delete();
                default: begin
                    pw.delete();
                    ed = 0;
                    exp_acc = 0;
                end
            endcase
            check("done", longint'(done), longint'(ed));
            check("acc", longint'(acc_out), exp_acc);
            if (done) begin
                done_cyc.push_back(cyc);
                done_val.push_back(longint'(acc_out));
            end
        end
    endtask

    function automatic longint dval(input int i);
        return (i < done_val.size()) ? done_val[i] : -1;
    endfunction

    function automatic int dcyc(input int i);
        return (i < done_cyc.size()) ? done_cyc[i] : -1;
    endfunction

    int first_cap;

    initial begin
        add_op(OP_RST, '0, '0, '0, 0, 0);
        add_op(OP_RST, '0, '0, '0, 0, 0);
        run_ops();
        check("reset_acc", longint'(acc_out), 0);
        check("reset_done", longint'(done), 0);

        for (int i = 0; i < 2048; i++) add_op(OP_LOAD, '0, 11'(i), 20'(i), 1, 1);
        run_ops();

        // all-zero addresses
        done_cyc.delete(); done_val.delete();
        first_cap = cyc + 1;
        add_word(fill(8'd0), fill(8'd0));
        add_op(OP_IDLE, '0, '0, '0, 0, 0);
        run_ops();
        check("all0_count", done_cyc.size(), 1);
        check("all0_acc", dval(0), -7168);
        check("all0_latency", dcyc(0) - first_cap, 16);

        done_cyc.delete(); done_val.delete();
        add_word(fill(8'd1), fill(8'd1));
        add_op(OP_IDLE, '0, '0, '0, 0, 0);
        run_ops();
        check("all1_acc", dval(0), -7176);

        done_cyc.delete(); done_val.delete();
        add_word(fill(8'd0), fill(8'd1));
        add_op(OP_IDLE, '0, '0, '0, 0, 0);
        run_ops();
        check("msb0_acc", dval(0), 254968);

        // back-to-back words with start held
        done_cyc.delete(); done_val.delete();
        add_word(fill(8'd0), fill(8'd0));
        add_word(fill(8'd1), fill(8'd1));
        add_op(OP_IDLE, '0, '0, '0, 0, 0);
        run_ops();
        check("b2b_count", done_cyc.size(), 2);
        check("b2b_spacing", dcyc(1) - dcyc(0), 16);
        check("b2b_acc0", dval(0), -7168);
        check("b2b_acc1", dval(1), -7176);

        // three-cycle load stall mid-word, writing ROM0[5]=100
        done_cyc.delete(); done_val.delete();
        first_cap = cyc + 1;
        for (int s = 0; s < 8; s++) add_op(OP_CAP, fill(8'd0), '0, '0, 0, 1);
        add_op(OP_LOAD, '0, 11'd5, 20'd100, 1, 1);
        add_op(OP_LOAD, '0, 11'h7ff, 20'hfffff, 0, 1);
        add_op(OP_LOAD, '0, 11'h005, 20'h12345, 0, 1);
        for (int s = 8; s < 16; s++) add_op(OP_CAP, fill(8'd0), '0, '0, 0, 1);
        add_op(OP_IDLE, '0, '0, '0, 0, 0);
        run_ops();
        check("stall_acc", dval(0), -7168);
        check("stall_latency", dcyc(0) - first_cap, 19);

        done_cyc.delete(); done_val.delete();
        begin
            logic [7:0][7:0] a5;
            a5 = fill(8'd0);
            a5[0] = 8'd5;
            add_word(a5, a5);
        end
        add_op(OP_IDLE, '0, '0, '0, 0, 0);
        run_ops();
        check("rom0_5_acc", dval(0), -7268);

        // reset mid-word
        done_cyc.delete(); done_val.delete();
        for (int s = 0; s < 5; s++) add_op(OP_CAP, fill(8'd1), '0, '0, 0, 1);
        add_op(OP_RST, '0, '0, '0, 0, 1);
        run_ops();
        check("midrst_acc", longint'(acc_out), 0);
        check("midrst_done", longint'(done), 0);
        add_word(fill(8'd0), fill(8'd0));
        add_op(OP_IDLE, '0, '0, '0, 0, 0);
        run_ops();
        check("midrst_count", done_cyc.size(), 1);
        check("after_rst_acc", dval(0), -7168);

        // randomized ROM image and op stream
        for (int i = 0; i < 400; i++)
            add_op(OP_LOAD, '0, 11'($urandom), 20'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
        run_ops();
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 82)
                add_op(OP_CAP, {$urandom, $urandom}, '0, '0, 0, 1);
            else if (r < 92)
                add_op(OP_LOAD, '0, 11'($urandom), 20'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            else if (r < 98)
                add_op(OP_IDLE, '0, '0, '0, 0, 0);
            else
                add_op(OP_RST, '0, '0, '0, 0, 1'($urandom));
        end
        add_op(OP_IDLE, '0, '0, '0, 0, 0);
        run_ops();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
